// File: rtl/mux_n_to_1_seq.sv
// mux_n_to_1_seq
//   Registered N-channel, W-bit multiplexer. The output is tagged with the
//   channel index it was taken from. Channels may be picked directly with a
//   sel_load strobe. When the MUX_SCAN_EN macro is defined, the block can
//   also step through the channels automatically, showing each one for DWELL
//   cycles.
//
//   Configuration macro: MUX_SCAN_EN
//     defined   - SCAN state, dwell counter and scan_en are built.
//     undefined - only IDLE/DIRECT exist; scan_en and DWELL are unused.
//
// Ports
//   clk       clock, all state on rising edge
//   rst_n     async active-low reset
//   din       packed channel data, channel i at din[i*W +: W]
//   sel       requested channel index
//   sel_load  one-cycle strobe, load sel as active channel
//   scan_en   level, enables auto-scan (MUX_SCAN_EN builds only)
//   dout      registered data of the active channel
//   ch_out    channel index dout came from
//   dout_vld  high once a channel has been chosen (DIRECT/SCAN)
//   sel_err   one-cycle pulse for a sel_load with sel >= N_CH
module mux_n_to_1_seq #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] din,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_load,
  input  logic              scan_en,
  output logic [W-1:0]      dout,
  output logic [SEL_W-1:0]  ch_out,
  output logic              dout_vld,
  output logic              sel_err
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  // One extra bit so the range check also works when N_CH is a power of two.
  localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH-1);

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       cur_ch, ch_nxt;
  logic [N_CH-1:0][W-1:0] ch_data;
  logic                   sel_ok, ld_ok, sel_bad;

  // Unpack the flat bus into one entry per channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_data[i] = din[i*W +: W];
  end

  assign sel_ok  = ({1'b0, sel} < N_CH_L);
  assign ld_ok   = sel_load & sel_ok;
  assign sel_bad = sel_load & ~sel_ok;

`ifdef MUX_SCAN_EN
  localparam int             DW_W    = $clog2(DWELL+1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL-1);

  logic [DW_W-1:0] dwell_cnt, dw_nxt;
`else
  // Present on the port list for a uniform interface; nothing uses them here.
  logic     unused_scan_en;
  localparam int unused_dwell = DWELL;
  assign unused_scan_en = scan_en;
`endif

  // Next state / channel / dwell. An out-of-range load freezes everything
  // for that cycle (only sel_err reacts), so it is handled first.
  always_comb begin
    state_nxt = state;
    ch_nxt    = cur_ch;
`ifdef MUX_SCAN_EN
    dw_nxt    = dwell_cnt;
`endif
    if (!sel_bad) begin
      if (ld_ok) ch_nxt = sel;
      case (state)
`ifdef MUX_SCAN_EN
        IDLE: begin
          if (scan_en) begin
            state_nxt = SCAN;
            if (!ld_ok) ch_nxt = '0;
            dw_nxt    = '0;
          end else if (ld_ok) begin
            state_nxt = DIRECT;
          end
        end
        DIRECT: begin
          if (scan_en) begin
            state_nxt = SCAN;
            dw_nxt    = '0;
          end
        end
        SCAN: begin
          if (!scan_en) begin
            // Leaving scan holds the channel; no advance on the exit edge.
            state_nxt = DIRECT;
            dw_nxt    = '0;
          end else if (ld_ok) begin
            // A load beats a pending advance and restarts the dwell.
            dw_nxt = '0;
          end else if (dwell_cnt == DW_LAST) begin
            ch_nxt = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
            dw_nxt = '0;
          end else begin
            dw_nxt = dwell_cnt + DW_W'(1);
          end
        end
`else
        IDLE:    if (ld_ok) state_nxt = DIRECT;
        DIRECT:  state_nxt = DIRECT;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_ch   <= '0;
      dout     <= '0;
      ch_out   <= '0;
      dout_vld <= 1'b0;
      sel_err  <= 1'b0;
`ifdef MUX_SCAN_EN
      dwell_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      cur_ch  <= ch_nxt;
      sel_err <= sel_bad;
`ifdef MUX_SCAN_EN
      dwell_cnt <= dw_nxt;
`endif
      // Outputs track din of the active channel every edge once a channel
      // is chosen, including the edge that leaves IDLE.
      if (state_nxt != IDLE) begin
        dout     <= ch_data[ch_nxt];
        ch_out   <= ch_nxt;
        dout_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_seq.sv
module tb_mux_n_to_1_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  // 4-channel DUT
  logic [31:0] din4;
  logic [1:0]  sel4, ch4;
  logic        ld4, scan4, vld4, err4;
  logic [7:0]  dout4;
  // 3-channel DUT (non power of two, for invalid selects)
  logic [23:0] din3;
  logic [1:0]  sel3, ch3;
  logic        ld3, scan3, vld3, err3;
  logic [7:0]  dout3;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      tag;
    logic [7:0] d;
    logic [1:0] c;
    logic       v;
    logic       e;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  logic [7:0] chv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  mux_n_to_1_seq #(.N_CH(4), .W(8), .DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .sel_load(ld4),
    .scan_en(scan4), .dout(dout4), .ch_out(ch4), .dout_vld(vld4), .sel_err(err4)
  );

  mux_n_to_1_seq #(.N_CH(3), .W(8), .DWELL(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .sel_load(ld3),
    .scan_en(scan3), .dout(dout3), .ch_out(ch3), .dout_vld(vld3), .sel_err(err3)
  );

  task automatic push4(input string t, input logic [7:0] d, input logic [1:0] c,
                       input logic v, input logic e);
    exp_t x;
    x.tag = t; x.d = d; x.c = c; x.v = v; x.e = e;
    q4.push_back(x);
  endtask

  task automatic push3(input string t, input logic [7:0] d, input logic [1:0] c,
                       input logic v, input logic e);
    exp_t x;
    x.tag = t; x.d = d; x.c = c; x.v = v; x.e = e;
    q3.push_back(x);
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed {dout,ch,vld,err}=%h expected %h", tag, got, exp);
  endtask

  task automatic drain();
    exp_t x;
    while (q4.size() > 0) begin
      x = q4.pop_front();
      check(x.tag, {dout4, ch4, vld4, err4}, {x.d, x.c, x.v, x.e});
    end
    while (q3.size() > 0) begin
      x = q3.pop_front();
      check(x.tag, {dout3, ch3, vld3, err3}, {x.d, x.c, x.v, x.e});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    din4  = 32'h44332211;
    din3  = 24'h332211;
    sel4 = '0; ld4 = 1'b0; scan4 = 1'b0;
    sel3 = '0; ld3 = 1'b0; scan3 = 1'b0;

    // Reset values, before and across a clock edge
    #2;
    push4("rst4", 8'h00, 2'd0, 1'b0, 1'b0);
    push3("rst3", 8'h00, 2'd0, 1'b0, 1'b0);
    drain();
    push4("rst4_edge", 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    #2 rst_n = 1'b1;

    // Direct load, 1-cycle latency
    push4("idle", 8'h00, 2'd0, 1'b0, 1'b0); tick();
    sel4 = 2'd2; ld4 = 1'b1;
    push4("load2", 8'h33, 2'd2, 1'b1, 1'b0); tick();
    ld4 = 1'b0;
    push4("hold2", 8'h33, 2'd2, 1'b1, 1'b0); tick();

    // din tracking and sel without strobe
    sel4 = 2'd1; ld4 = 1'b1;
    push4("load1", 8'h22, 2'd1, 1'b1, 1'b0); tick();
    ld4 = 1'b0;
    din4[15:8] = 8'h5A;
    push4("track", 8'h5A, 2'd1, 1'b1, 1'b0); tick();
    sel4 = 2'd3;
    push4("no_strobe", 8'h5A, 2'd1, 1'b1, 1'b0); tick();
    din4 = 32'h44332211;
    push4("restore", 8'h22, 2'd1, 1'b1, 1'b0); tick();
    sel4 = 2'd0; ld4 = 1'b1;
    push4("load0", 8'h11, 2'd0, 1'b1, 1'b0); tick();
    ld4 = 1'b0;

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    push4("async_rst", 8'h00, 2'd0, 1'b0, 1'b0); drain();
    push4("rst_held", 8'h00, 2'd0, 1'b0, 1'b0); tick();
    #2 rst_n = 1'b1;

`ifndef MUX_SCAN_EN
    // scan_en has no effect: stays IDLE, then holds the loaded channel
    scan4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push4("scan_ignored", 8'h00, 2'd0, 1'b0, 1'b0); tick();
    end
    sel4 = 2'd3; ld4 = 1'b1;
    push4("load3_noscan", 8'h44, 2'd3, 1'b1, 1'b0); tick();
    ld4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push4("no_advance", 8'h44, 2'd3, 1'b1, 1'b0); tick();
    end
    scan4 = 1'b0;
`else
    // Scan from IDLE: 4 cycles per channel, wrap to channel 0
    scan4 = 1'b1;
    for (int c = 0; c < 5; c++)
      for (int k = 0; k < 4; k++) begin
        push4("scan_rot", chv[c % 4], 2'(c % 4), 1'b1, 1'b0); tick();
      end
    // ch1 until count 2, then load ch3 mid-dwell
    for (int k = 0; k < 3; k++) begin
      push4("scan_ch1", chv[1], 2'd1, 1'b1, 1'b0); tick();
    end
    sel4 = 2'd3; ld4 = 1'b1;
    push4("scan_load3", chv[3], 2'd3, 1'b1, 1'b0); tick();
    ld4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push4("scan_ch3_dwell", chv[3], 2'd3, 1'b1, 1'b0); tick();
    end
    push4("scan_after_load", chv[0], 2'd0, 1'b1, 1'b0); tick();
    // Leave scan: channel held
    scan4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push4("direct_hold", chv[0], 2'd0, 1'b1, 1'b0); tick();
    end
    // Re-enter scan, then reset mid-scan
    scan4 = 1'b1;
    push4("rescan", chv[0], 2'd0, 1'b1, 1'b0); tick();
    push4("rescan1", chv[0], 2'd0, 1'b1, 1'b0); tick();
    #3 rst_n = 1'b0;
    #1;
    push4("rst_midscan", 8'h00, 2'd0, 1'b0, 1'b0); drain();
    push4("rst_midscan_edge", 8'h00, 2'd0, 1'b0, 1'b0); tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push4("restart_ch0", chv[0], 2'd0, 1'b1, 1'b0); tick();
    end
    push4("restart_ch1", chv[1], 2'd1, 1'b1, 1'b0); tick();
    // sel_load together with scan_en from IDLE
    rst_n = 1'b0; scan4 = 1'b0;
    push4("rst3", 8'h00, 2'd0, 1'b0, 1'b0); tick();
    #2 rst_n = 1'b1;
    sel4 = 2'd2; ld4 = 1'b1; scan4 = 1'b1;
    push4("load_scan_idle", chv[2], 2'd2, 1'b1, 1'b0); tick();
    ld4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push4("scan_ch2", chv[2], 2'd2, 1'b1, 1'b0); tick();
    end
    for (int k = 0; k < 4; k++) begin
      push4("scan_ch3", chv[3], 2'd3, 1'b1, 1'b0); tick();
    end
    // Load on the advance edge: load wins
    sel4 = 2'd1; ld4 = 1'b1;
    push4("load_on_advance", chv[1], 2'd1, 1'b1, 1'b0); tick();
    ld4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push4("scan_ch1_full", chv[1], 2'd1, 1'b1, 1'b0); tick();
    end
    push4("scan_ch2_next", chv[2], 2'd2, 1'b1, 1'b0); tick();
    scan4 = 1'b0;
    push4("exit_scan", chv[2], 2'd2, 1'b1, 1'b0); tick();
`endif

    // 3-channel DUT: invalid selects
    sel3 = 2'd3; ld3 = 1'b1;
    push3("bad_idle", 8'h00, 2'd0, 1'b0, 1'b1); tick();
    ld3 = 1'b0;
    push3("bad_idle_after", 8'h00, 2'd0, 1'b0, 1'b0); tick();
    sel3 = 2'd1; ld3 = 1'b1;
    push3("load1_n3", 8'h22, 2'd1, 1'b1, 1'b0); tick();
    sel3 = 2'd3;
    push3("bad_direct", 8'h22, 2'd1, 1'b1, 1'b1); tick();
    ld3 = 1'b0;
    push3("bad_clear", 8'h22, 2'd1, 1'b1, 1'b0); tick();
    sel3 = 2'd2; ld3 = 1'b1;
    push3("load_max", 8'h33, 2'd2, 1'b1, 1'b0); tick();
    ld3 = 1'b0;
    push3("hold_max", 8'h33, 2'd2, 1'b1, 1'b0); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
